// File: rtl/result_ram_streamer.sv
`default_nettype none
// ============================================================================
// Module   : result_ram_streamer
// Brief    : Walks the result RAM once per frame (row-major or transposed),
//            optionally saturates each word, and streams it out over a
//            valid/ready interface through a 2-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module result_ram_streamer #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int ROW_LEN   = 8,
    parameter int DATA_W    = 19,
    parameter int OUT_W     = 19,
    parameter int TRANSPOSE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic signed [DATA_W-1:0] ram_rdata,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_n;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_sat;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [OUT_W-1:0]    r_data0;
    logic [OUT_W-1:0]    r_data1;
    logic                r_last0;
    logic                r_last1;
    logic                r_v0;
    logic                r_v1;

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [1:0]          w_occ;
    logic [OUT_W-1:0]    w_sat_data;
    logic                w_clip;

    // Element index -> RAM address; the transposed walk swaps row and column.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] idx);
        int i;
        int r;
        int c;
        i = int'(idx);
        r = i / ROW_LEN;
        c = i % ROW_LEN;
        if (TRANSPOSE != 0)
            addr_of = ADDR_W'(c * ROW_LEN + r);
        else
            addr_of = idx;
    endfunction

    // Occupancy counts the word leaving this cycle as already gone, so a
    // steady ready=1 stream never stalls while a held-off stream never
    // needs more than two skid slots.
    assign w_pop   = r_v0 & out_ready;
    assign w_push  = r_inflight;
    assign w_occ   = 2'(r_v0) + 2'(r_v1) + 2'(r_inflight) - 2'(w_pop);
    assign w_issue = (r_state == S_RUN) && (w_occ < 2'd2);

    generate
        if (OUT_W < DATA_W) begin : g_sat
            // All bits above the output sign bit must equal it, else clip.
            logic [DATA_W-OUT_W:0] w_top;
            assign w_top      = ram_rdata[DATA_W-1:OUT_W-1];
            assign w_clip     = !((&w_top) || !(|w_top));
            assign w_sat_data = !w_clip ? ram_rdata[OUT_W-1:0] :
                                ram_rdata[DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                                      {1'b0, {(OUT_W-1){1'b1}}};
        end else begin : g_pass
            assign w_clip     = 1'b0;
            assign w_sat_data = ram_rdata;
        end
    endgenerate

    // Frame control: start acceptance, read issue, and end-of-frame done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_n             <= '0;
            r_ram_addr      <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_sat           <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue)
                r_inflight_last <= (r_n == c_last_idx);
            if (w_push && w_clip)
                r_sat <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_n        <= '0;
                        r_ram_addr <= addr_of('0);
                        r_busy     <= 1'b1;
                        r_sat      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (r_n == c_last_idx) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_n        <= r_n + ADDR_W'(1);
                            r_ram_addr <= addr_of(r_n + ADDR_W'(1));
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_pop && r_last0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid FIFO; slot 0 is the head and drives the output port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
        end else if (w_pop) begin
            if (r_v1) begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
                r_v0    <= 1'b1;
                r_data1 <= w_sat_data;
                r_last1 <= w_push & r_inflight_last;
                r_v1    <= w_push;
            end else begin
                r_data0 <= w_push ? w_sat_data : r_data0;
                r_last0 <= w_push & r_inflight_last;
                r_v0    <= w_push;
                r_v1    <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_v0) begin
                r_data0 <= w_sat_data;
                r_last0 <= r_inflight_last;
                r_v0    <= 1'b1;
            end else begin
                r_data1 <= w_sat_data;
                r_last1 <= r_inflight_last;
                r_v1    <= 1'b1;
            end
        end
    end

    assign ram_addr  = r_ram_addr;
    assign out_data  = r_data0;
    assign out_valid = r_v0;
    assign out_last  = r_last0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sat_flag  = r_sat;

endmodule
`default_nettype wire
